// File: rtl/lut_ram_arb_pkg.sv
// Shared types and the round-robin pick helper for the LUT RAM arbiter.
// Request payload struct is built by a width-parameterised macro.
`ifndef LUT_RAM_ARB_PKG_SV
`define LUT_RAM_ARB_PKG_SV

`define LUT_RAM_ARB_REQ_T(AW, DW) \
  struct packed { \
    logic            we; \
    logic [(AW)-1:0] addr; \
    logic [(DW)-1:0] wdata; \
  }

package lut_ram_arb_pkg;

  localparam int XLEN        = 32;
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_ADDR_W  = $clog2(DEF_DEPTH);
  localparam int MAX_REQ     = 8;

  typedef `LUT_RAM_ARB_REQ_T(DEF_ADDR_W, XLEN) arb_req_t;

  // One-hot pick of the first valid index at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] g;
    logic [2:0]         idx;
    g = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && g == '0 && valid[idx])
        g[idx] = 1'b1;
    end
    return g;
  endfunction

endpackage

`endif

// File: rtl/lut_ram_arb_if.sv
// Requester-side handshake and response bundle for lut_ram_arbiter.
// master = requester side, slave = arbiter side.
interface lut_ram_arb_if #(
  parameter int NUM_REQ   = 2,
  parameter int LUT_WIDTH = 32,
  parameter int ADDR_W    = 10,
  parameter int ID_W      = 1
);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0]                req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr;
  logic [NUM_REQ-1:0][LUT_WIDTH-1:0] req_wdata;

  logic                 resp_valid;
  logic [ID_W-1:0]      resp_id;
  logic [LUT_WIDTH-1:0] resp_rdata;
  logic                 resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_id, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_id, resp_rdata, resp_err
  );

endinterface

// File: rtl/lut_ram_rr_arb.sv
// Grant logic and pointer register for lut_ram_arbiter.
// LUT_RAM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module lut_ram_rr_arb
  import lut_ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant
);

  logic [2:0]         r_ptr;
  logic [MAX_REQ-1:0] w_v8;

  always_comb begin
    w_v8 = '0;
    w_v8[NUM_REQ-1:0] = valid;
  end

  assign grant = rst_n
    ? NUM_REQ'(rr_pick(w_v8, r_ptr, NUM_REQ))
    : '0;

`ifdef LUT_RAM_ARB_FIXED_PRIO_EN
  // Pointer parked at zero: search always starts at index 0.
  always_ff @(posedge clk) begin
    r_ptr <= '0;
  end
`else
  logic [2:0] w_nxt;

  always_comb begin
    w_nxt = r_ptr;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i])
        w_nxt = (i == NUM_REQ - 1) ? 3'd0 : 3'(i + 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ptr <= '0;
    else
      r_ptr <= w_nxt;
  end
`endif

endmodule

// File: rtl/lut_ram_arbiter.sv
// Shares one lut_ram (sync write, comb read) among NUM_REQ requesters.
// Optional macro: LUT_RAM_ARB_FIXED_PRIO_EN (fixed priority instead of RR).
module lut_ram_arbiter
  import lut_ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int LUT_WIDTH = XLEN,
  parameter int LUT_DEPTH = DEF_DEPTH,
  parameter int ADDR_W    = $clog2(LUT_DEPTH),
  parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lut_ram_arb_if.slave         bus,
  output logic                 lut_wr_en,
  output logic [ADDR_W-1:0]    lut_wr_addr,
  output logic [ADDR_W-1:0]    lut_rd_addr,
  output logic [LUT_WIDTH-1:0] lut_wr_data,
  input  logic [LUT_WIDTH-1:0] lut_rd_data
);

  typedef `LUT_RAM_ARB_REQ_T(ADDR_W, LUT_WIDTH) req_t;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_any;
  logic [ID_W-1:0]    w_gidx;
  req_t               w_sel;
  logic               w_inr;

  logic                 r_valid;
  logic [ID_W-1:0]      r_id;
  logic [LUT_WIDTH-1:0] r_rdata;
  logic                 r_err;

  lut_ram_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (bus.req_valid),
    .grant (w_grant)
  );

  // Winner mux; all-zero payload when nothing is granted.
  always_comb begin
    w_gidx = '0;
    w_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx      = ID_W'(i);
        w_sel.we    = bus.req_we[i];
        w_sel.addr  = bus.req_addr[i];
        w_sel.wdata = bus.req_wdata[i];
      end
    end
  end

  assign w_any = |w_grant;
  assign w_inr = 32'(w_sel.addr) < 32'(LUT_DEPTH);

  assign bus.req_ready = w_grant;

  assign lut_wr_en   = w_any & w_sel.we & w_inr;
  assign lut_wr_addr = w_sel.addr;
  assign lut_wr_data = w_sel.wdata;
  assign lut_rd_addr = w_inr ? w_sel.addr : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_any) begin
      r_valid <= 1'b1;
      r_id    <= w_gidx;
      r_rdata <= w_inr ? lut_rd_data : '0;
      r_err   <= ~w_inr;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  assign bus.resp_valid = r_valid;
  assign bus.resp_id    = r_id;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_lut_ram_arbiter.sv
// Scoreboard bench for lut_ram_arbiter: directed requests, queued responses.
// Uses LUT_DEPTH=1000 so addresses 1000..1023 are out of range.
module tb_lut_ram_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int AW = 10;
`ifdef LUT_RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          lut_wr_en;
  logic [AW-1:0] lut_wr_addr;
  logic [AW-1:0] lut_rd_addr;
  logic [DW-1:0] lut_wr_data;
  logic [DW-1:0] lut_rd_data;
  logic [DW-1:0] mem [1024];

  typedef struct packed {
    logic          id;
    logic [DW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  lut_ram_arb_if #(.NUM_REQ(NR), .LUT_WIDTH(DW),
                   .ADDR_W(AW), .ID_W(1)) bus ();

  lut_ram_arbiter #(
    .NUM_REQ   (NR),
    .LUT_WIDTH (DW),
    .LUT_DEPTH (1000),
    .ADDR_W    (AW),
    .ID_W      (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_addr (lut_wr_addr),
    .lut_rd_addr (lut_rd_addr),
    .lut_wr_data (lut_wr_data),
    .lut_rd_data (lut_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  end

  always @(posedge clk)
    if (lut_wr_en) mem[lut_wr_addr] <= lut_wr_data;

  assign lut_rd_data = mem[lut_rd_addr];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response monitor: every resp_valid must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("resp_id", 64'(bus.resp_id), 64'(e.id));
        chk("resp_rdata", 64'(bus.resp_rdata), 64'(e.rd));
        chk("resp_err", 64'(bus.resp_err), 64'(e.err));
      end
    end
  end

  task automatic step(input logic [1:0]    v,
                      input logic [1:0]    we,
                      input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1,
                      input logic [1:0]    erdy,
                      input logic          ewen,
                      input logic [DW-1:0] erd,
                      input logic          eerr);
    logic [AW-1:0] erda;
    bus.req_valid    = v;
    bus.req_we       = we;
    bus.req_addr[0]  = a0;
    bus.req_addr[1]  = a1;
    bus.req_wdata[0] = d0;
    bus.req_wdata[1] = d1;
    erda = (erdy == 2'b00 || eerr) ? '0 : (erdy[1] ? a1 : a0);
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'(erdy));
    chk("lut_wr_en", 64'(lut_wr_en), 64'(ewen));
    chk("lut_rd_addr", 64'(lut_rd_addr), 64'(erda));
    if (erdy != 2'b00) q.push_back('{id: erdy[1], rd: erd, err: eerr});
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] erdy;
    rst_n = 1'b0;
    bus.req_valid    = 2'b11;
    bus.req_we       = 2'b11;
    bus.req_addr[0]  = 10'd5;
    bus.req_addr[1]  = 10'd5;
    bus.req_wdata[0] = 32'hFFFF_FFFF;
    bus.req_wdata[1] = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_wr_en", 64'(lut_wr_en), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // write then read from req0
    step(2'b01, 2'b01, 10'd5, 10'd0, 32'hDEADBEEF, 0, 2'b01, 1, 32'h0, 0);
    step(2'b01, 2'b00, 10'd5, 10'd0, 0, 0, 2'b01, 0, 32'hDEADBEEF, 0);
    // req1 alone, leaves the RR pointer at 0
    step(2'b10, 2'b00, 10'd0, 10'd7, 0, 0, 2'b10, 0, 32'h0, 0);

    for (int k = 0; k < 4; k++) begin
      erdy = (FIXED || (k % 2 == 0)) ? 2'b01 : 2'b10;
      step(2'b11, 2'b00, 10'd5, 10'd5, 0, 0, erdy, 0, 32'hDEADBEEF, 0);
    end
    step(2'b00, 2'b00, 10'd0, 10'd0, 0, 0, 2'b00, 0, 32'h0, 0);
    chk("idle_valid", 64'(bus.resp_valid), 64'd0);
    chk("idle_rdata_hold", 64'(bus.resp_rdata), 64'hDEADBEEF);
    chk("idle_err", 64'(bus.resp_err), 64'd0);
    step(2'b11, 2'b00, 10'd5, 10'd5, 0, 0, 2'b01, 0, 32'hDEADBEEF, 0);
    step(2'b10, 2'b00, 10'd0, 10'd6, 0, 0, 2'b10, 0, 32'h0, 0);

    // contention on addr 3
    step(2'b11, 2'b01, 10'd3, 10'd3, 32'h11, 0, 2'b01, 1, 32'h0, 0);
    step(2'b10, 2'b00, 10'd3, 10'd3, 0, 0, 2'b10, 0, 32'h11, 0);

    // out of range
    step(2'b01, 2'b01, 10'd0, 10'd0, 32'hA5, 0, 2'b01, 1, 32'h0, 0);
    step(2'b01, 2'b01, 10'd1000, 10'd0, 32'hBAD, 0, 2'b01, 0, 32'h0, 1);
    step(2'b01, 2'b00, 10'd0, 10'd0, 0, 0, 2'b01, 0, 32'hA5, 0);
    step(2'b01, 2'b00, 10'd1023, 10'd0, 0, 0, 2'b01, 0, 32'h0, 1);

    // mid-operation reset: granted read is dropped
    bus.req_valid   = 2'b01;
    bus.req_we      = 2'b00;
    bus.req_addr[0] = 10'd5;
    @(negedge clk);
    chk("pre_rst_ready", 64'(bus.req_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gate", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("mid_rst_no_resp", 64'(bus.resp_valid), 64'd0);
    @(posedge clk);
    #1;
    // pointer back at 0 -> req0 wins
    step(2'b11, 2'b00, 10'd5, 10'd5, 0, 0, 2'b01, 0, 32'hDEADBEEF, 0);
    step(2'b00, 2'b00, 10'd0, 10'd0, 0, 0, 2'b00, 0, 32'h0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("drain", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
